// File: rtl/neopixel_pkg.sv
// Shared types and 40 MHz default timing for the multi-strip WS2812 driver.
package neopixel_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_SEND  = 2'd2,
      ST_LATCH = 2'd3
   } np_state_t;

   localparam int NP_NUM_STRIPS = 8;
   localparam int NP_MAX_BYTES  = 75;
   localparam int NP_T_BIT      = 50;
   localparam int NP_T0H        = 16;
   localparam int NP_T1H        = 32;
   localparam int NP_RESET_CYC  = 2000;

   // High-time of one encoded WS2812 bit.
   function automatic int high_cycles(input logic bit_val, input int t0h, input int t1h);
      return bit_val ? t1h : t0h;
   endfunction

endpackage

// File: rtl/neopixel_strip_lane.sv
// One output lane: byte RAM, shift/next-byte registers and the pulse compare.
// With NEOPIXEL_DOUBLE_BUFFER_EN the RAM holds a front and a back bank.
module neopixel_strip_lane
   import neopixel_pkg::*;
#(
   parameter int MAX_BYTES = NP_MAX_BYTES,
   parameter int T0H       = NP_T0H,
   parameter int T1H       = NP_T1H,
   parameter int AW        = $clog2(NP_MAX_BYTES),
   parameter int PW        = $clog2(NP_T_BIT)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic          wr_bank,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic          rd_bank,
   input  logic [AW-1:0] rd_addr,
   input  logic          lane_en,
   input  logic          load_sr,
   input  logic          shift_sr,
   input  logic          byte_end,
   input  logic          capture_nb,
   input  logic          send_next,
   input  logic [PW-1:0] phase_next,
   output logic          pulse_out
);

   logic [7:0] rd_data_r;
   logic [7:0] sr_r;
   logic [7:0] nb_r;
   logic [7:0] sr_next_s;
   logic       pulse_r;

`ifdef NEOPIXEL_DOUBLE_BUFFER_EN
   logic [7:0] mem_r [2][MAX_BYTES];

   // Banked byte RAM with registered read port.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[wr_bank][wr_addr] <= wr_data;
      end
      rd_data_r <= mem_r[rd_bank][rd_addr];
   end
`else
   logic [7:0] mem_r [MAX_BYTES];
   logic       unused_bank_s;

   assign unused_bank_s = wr_bank ^ rd_bank;

   // Single-bank byte RAM with registered read port.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
      rd_data_r <= mem_r[rd_addr];
   end
`endif

   // Shift register: load first byte, shift per bit, refill from next-byte reg.
   always_comb begin
      sr_next_s = sr_r;
      if (load_sr) begin
         sr_next_s = rd_data_r;
      end else if (shift_sr && byte_end) begin
         sr_next_s = nb_r;
      end else if (shift_sr) begin
         sr_next_s = {sr_r[6:0], 1'b0};
      end else begin
         sr_next_s = sr_r;
      end
   end

   // Output is computed from next-cycle values so it lines up with the shared phase.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr_r    <= 8'd0;
         nb_r    <= 8'd0;
         pulse_r <= 1'b0;
      end else begin
         sr_r    <= sr_next_s;
         if (capture_nb) begin
            nb_r <= rd_data_r;
         end else begin
            nb_r <= nb_r;
         end
         pulse_r <= send_next && lane_en &&
                    (int'(phase_next) < high_cycles(sr_next_s[7], T0H, T1H));
      end
   end

   assign pulse_out = pulse_r;

endmodule

// File: rtl/neopixel_multi_strip.sv
// Multi-lane WS2812 serialiser: shared FSM and bit timebase driving NUM_STRIPS lanes.
// Optional NEOPIXEL_DOUBLE_BUFFER_EN gives each lane a front/back bank swapped on flush.
module neopixel_multi_strip
   import neopixel_pkg::*;
#(
   parameter int NUM_STRIPS = NP_NUM_STRIPS,
   parameter int MAX_BYTES  = NP_MAX_BYTES,
   parameter int T_BIT      = NP_T_BIT,
   parameter int T0H        = NP_T0H,
   parameter int T1H        = NP_T1H,
   parameter int RESET_CYC  = NP_RESET_CYC
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          write_en,
   input  logic [$clog2(NUM_STRIPS)-1:0] write_strip,
   input  logic [7:0]                    write_addr,
   input  logic [7:0]                    write_data,
   input  logic                          flush,
   input  logic [7:0]                    flush_len,
   input  logic [NUM_STRIPS-1:0]         flush_mask,
   output logic                          busy,
   output logic [NUM_STRIPS-1:0]         data_out
);

   localparam int AW = $clog2(MAX_BYTES);
   localparam int LW = $clog2(MAX_BYTES + 1);
   localparam int PW = $clog2(T_BIT);
   localparam int CW = $clog2(RESET_CYC);

   np_state_t             state_r, state_n;
   logic                  fetch_r, fetch_n;
   logic [PW-1:0]         phase_r, phase_n;
   logic [2:0]            bit_r, bit_n;
   logic [LW-1:0]         byte_r, byte_n;
   logic [LW-1:0]         len_r, len_n;
   logic [NUM_STRIPS-1:0] mask_r, mask_n;
   logic [CW-1:0]         latch_r, latch_n;
   logic                  bank_r, bank_n;
   logic                  busy_r;

   logic                  load_sr_s, shift_s, byte_end_s, capture_nb_s;
   logic [LW-1:0]         nxt_byte_s;
   logic [AW-1:0]         rd_addr_s;
   logic                  wr_ok_s;
   logic [NUM_STRIPS-1:0] data_out_s;

   // State and shared counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
         fetch_r <= 1'b0;
         phase_r <= '0;
         bit_r   <= 3'd7;
         byte_r  <= '0;
         len_r   <= '0;
         mask_r  <= '0;
         latch_r <= '0;
         bank_r  <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_n;
         fetch_r <= fetch_n;
         phase_r <= phase_n;
         bit_r   <= bit_n;
         byte_r  <= byte_n;
         len_r   <= len_n;
         mask_r  <= mask_n;
         latch_r <= latch_n;
         bank_r  <= bank_n;
         busy_r  <= (state_n != ST_IDLE);
      end
   end

   // Next-state, counter updates and lane control strobes.
   always_comb begin
      state_n      = state_r;
      fetch_n      = fetch_r;
      phase_n      = phase_r;
      bit_n        = bit_r;
      byte_n       = byte_r;
      len_n        = len_r;
      mask_n       = mask_r;
      latch_n      = latch_r;
      bank_n       = bank_r;
      load_sr_s    = 1'b0;
      shift_s      = 1'b0;
      byte_end_s   = 1'b0;
      capture_nb_s = 1'b0;
      rd_addr_s    = '0;
      nxt_byte_s   = byte_r + LW'(1);
      case (state_r)
         ST_IDLE: begin
            if (flush && (flush_len != 8'd0)) begin
               state_n = ST_FETCH;
               fetch_n = 1'b0;
               byte_n  = '0;
               mask_n  = flush_mask;
               if (32'(flush_len) > MAX_BYTES) begin
                  len_n = LW'(MAX_BYTES);
               end else begin
                  len_n = LW'(flush_len);
               end
`ifdef NEOPIXEL_DOUBLE_BUFFER_EN
               bank_n = ~bank_r;
`endif
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_FETCH: begin
            rd_addr_s = '0;
            if (fetch_r) begin
               state_n   = ST_SEND;
               load_sr_s = 1'b1;
               phase_n   = '0;
               bit_n     = 3'd7;
            end else begin
               fetch_n = 1'b1;
            end
         end
         ST_SEND: begin
            // Prefetch the following byte; stay in range on the final byte.
            if (32'(nxt_byte_s) < MAX_BYTES) begin
               rd_addr_s = AW'(nxt_byte_s);
            end else begin
               rd_addr_s = AW'(byte_r);
            end
            if (phase_r == PW'(T_BIT - 1)) begin
               phase_n      = '0;
               shift_s      = 1'b1;
               capture_nb_s = (bit_r == 3'd7);
               if (bit_r == 3'd0) begin
                  byte_end_s = 1'b1;
                  bit_n      = 3'd7;
                  if (nxt_byte_s == len_r) begin
                     state_n = ST_LATCH;
                     latch_n = '0;
                  end else begin
                     byte_n = nxt_byte_s;
                  end
               end else begin
                  bit_n = bit_r - 3'd1;
               end
            end else begin
               phase_n = phase_r + PW'(1);
            end
         end
         ST_LATCH: begin
            if (latch_r == CW'(RESET_CYC - 1)) begin
               state_n = ST_IDLE;
            end else begin
               latch_n = latch_r + CW'(1);
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // Write acceptance: range checks on the full-width inputs before truncation.
   always_comb begin
      wr_ok_s = write_en && (32'(write_addr) < MAX_BYTES) &&
                (32'(write_strip) < NUM_STRIPS);
`ifndef NEOPIXEL_DOUBLE_BUFFER_EN
      if (state_r != ST_IDLE) begin
         wr_ok_s = 1'b0;
      end else begin
         wr_ok_s = wr_ok_s;
      end
`endif
   end

   for (genvar i = 0; i < NUM_STRIPS; i++) begin : g_lane
      neopixel_strip_lane #(
         .MAX_BYTES (MAX_BYTES),
         .T0H       (T0H),
         .T1H       (T1H),
         .AW        (AW),
         .PW        (PW)
      ) u_lane (
         .clk        (clk),
         .reset      (reset),
         .wr_en      (wr_ok_s && (32'(write_strip) == i)),
         .wr_bank    (~bank_r),
         .wr_addr    (AW'(write_addr)),
         .wr_data    (write_data),
         .rd_bank    (bank_r),
         .rd_addr    (rd_addr_s),
         .lane_en    (mask_r[i]),
         .load_sr    (load_sr_s),
         .shift_sr   (shift_s),
         .byte_end   (byte_end_s),
         .capture_nb (capture_nb_s),
         .send_next  (state_n == ST_SEND),
         .phase_next (phase_n),
         .pulse_out  (data_out_s[i])
      );
   end

   assign busy     = busy_r;
   assign data_out = data_out_s;

endmodule

// File: tb/tb_neopixel_multi_strip.sv
// Scoreboard bench: stimulus predicts every pulse (rise cycle, width) and busy window
// from the WS2812 timing rules; an independent monitor measures and compares them.
module tb_neopixel_multi_strip;

   localparam int NS = 8;
   localparam int MB = 75;
   localparam int TB = 50;
   localparam int T0 = 16;
   localparam int T1 = 32;
   localparam int RC = 2000;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          write_en = 1'b0;
   logic [2:0]    write_strip = 3'd0;
   logic [7:0]    write_addr = 8'd0;
   logic [7:0]    write_data = 8'd0;
   logic          flush = 1'b0;
   logic [7:0]    flush_len = 8'd0;
   logic [NS-1:0] flush_mask = '0;
   logic          busy;
   logic [NS-1:0] data_out;

   neopixel_multi_strip dut (
      .clk         (clk),
      .reset       (reset),
      .write_en    (write_en),
      .write_strip (write_strip),
      .write_addr  (write_addr),
      .write_data  (write_data),
      .flush       (flush),
      .flush_len   (flush_len),
      .flush_mask  (flush_mask),
      .busy        (busy),
      .data_out    (data_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int lane; int rise; int width; } pulse_t;
   typedef struct { int start; int len; } busy_t;

   pulse_t     pq[$];
   busy_t      bq[$];
   int         tests = 0;
   int         fails = 0;
   logic [7:0] img [2][NS][MB];
   int         front = 0;
   int         busy_end = -1;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int wbank();
`ifdef NEOPIXEL_DOUBLE_BUFFER_EN
      return 1 - front;
`else
      return 0;
`endif
   endfunction

   task automatic do_write(input int strip, input int addr, input logic [7:0] data);
      int e;
      @(negedge clk);
      write_en = 1'b1; write_strip = strip[2:0]; write_addr = addr[7:0]; write_data = data;
      @(posedge clk); #1;
      e = cyc;
      write_en = 1'b0;
`ifdef NEOPIXEL_DOUBLE_BUFFER_EN
      if (addr < MB && strip < NS) img[wbank()][strip][addr] = data;
`else
      if (addr < MB && strip < NS && e > busy_end) img[wbank()][strip][addr] = data;
`endif
   endtask

   task automatic do_flush(input int len, input logic [NS-1:0] mask);
      int e, l, bk;
      @(negedge clk);
      flush = 1'b1; flush_len = len[7:0]; flush_mask = mask;
      @(posedge clk); #1;
      e = cyc;
      flush = 1'b0;
      if (e > busy_end && len != 0) begin
         l = (len > MB) ? MB : len;
`ifdef NEOPIXEL_DOUBLE_BUFFER_EN
         front = 1 - front;
`endif
         bk = (wbank() == 0) ? 1 : 0;
`ifndef NEOPIXEL_DOUBLE_BUFFER_EN
         bk = 0;
`endif
         for (int i = 0; i < NS; i++) begin
            if (mask[i]) begin
               for (int b = 0; b < l; b++) begin
                  for (int k = 7; k >= 0; k--) begin
                     pq.push_back('{i, e + 2 + (b * 8 + 7 - k) * TB,
                                    img[bk][i][b][k] ? T1 : T0});
                  end
               end
            end
         end
         bq.push_back('{e, 2 + 8 * l * TB + RC});
         busy_end = e + 2 + 8 * l * TB + RC;
      end
   endtask

   task automatic wait_idle();
      while (cyc <= busy_end + 2) @(posedge clk);
      #1;
   endtask

   task automatic check_pulse(input int lane, input int rise, input int width);
      int k;
      k = -1;
      for (int j = 0; j < pq.size(); j++) begin
         if (k < 0 && pq[j].lane == lane) k = j;
      end
      tests++;
      if (k < 0) begin
         fails++;
         $display("FAIL unexpected_pulse lane%0d: rise %0d width %0d, none expected", lane, rise, width);
      end else begin
         if (pq[k].rise != rise || pq[k].width != width) begin
            fails++;
            $display("FAIL pulse lane%0d: rise %0d width %0d, expected rise %0d width %0d",
                     lane, rise, width, pq[k].rise, pq[k].width);
         end
         pq.delete(k);
      end
   endtask

   // Monitor: measures pulses and busy windows, pops and compares expectations.
   initial begin
      logic [NS-1:0] prev_do;
      logic          prev_busy;
      int            rise_at [NS];
      int            busy_rise;
      prev_do = '0; prev_busy = 1'b0; busy_rise = 0;
      for (int i = 0; i < NS; i++) rise_at[i] = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            pq.delete(); bq.delete();
            prev_do = '0; prev_busy = 1'b0;
         end else begin
            for (int i = 0; i < NS; i++) begin
               if (data_out[i] && !prev_do[i]) rise_at[i] = cyc;
               else if (!data_out[i] && prev_do[i]) check_pulse(i, rise_at[i], cyc - rise_at[i]);
            end
            if (busy && !prev_busy) busy_rise = cyc;
            else if (!busy && prev_busy) begin
               tests++;
               if (bq.size() == 0) begin
                  fails++;
                  $display("FAIL unexpected_busy: start %0d len %0d, none expected", busy_rise, cyc - busy_rise);
               end else begin
                  busy_t b;
                  b = bq.pop_front();
                  if (b.start != busy_rise || b.len != cyc - busy_rise) begin
                     fails++;
                     $display("FAIL busy_window: start %0d len %0d, expected start %0d len %0d",
                              busy_rise, cyc - busy_rise, b.start, b.len);
                  end
               end
            end
            prev_do = data_out; prev_busy = busy;
         end
      end
   end

   initial begin
      int len;
      logic [NS-1:0] mask;
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < NS; i++)
            for (int a = 0; a < MB; a++) img[b][i][a] = 8'd0;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", busy, 0);
      chk("reset_data_out", data_out, 0);
      @(negedge clk) reset = 1'b0;
      repeat (2) @(posedge clk);

      // Single byte 0xA5 on lane 0, then a write during busy and a re-flush.
      do_write(0, 0, 8'hA5);
      do_flush(1, 8'h01);
      repeat (100) @(posedge clk);
      do_write(0, 0, 8'h3C);
      wait_idle();
      do_flush(1, 8'h01);
      wait_idle();

      // Three bytes on lanes 0 and 3 with an ignored flush mid-stream.
      do_write(0, 0, 8'hFF); do_write(0, 1, 8'h00); do_write(0, 2, 8'h81);
      do_write(3, 0, 8'h00); do_write(3, 1, 8'hFF); do_write(3, 2, 8'h18);
      do_flush(3, 8'h09);
      repeat (300) @(posedge clk);
      do_flush(1, 8'hFF);
      wait_idle();

      // Zero-length flush is ignored.
      do_flush(0, 8'h01);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("len0_busy", busy, 0);
      end

      // Length clamp to MAX_BYTES.
      for (int a = 0; a < MB; a++) do_write(5, a, 8'($urandom));
      do_flush(200, 8'h20);
      wait_idle();

      // Reset mid-byte, then replay.
      do_write(2, 0, 8'h96);
      do_flush(1, 8'h04);
      repeat (2 + 3 * TB + 10) @(posedge clk);
      #1;
      chk("pre_reset_high", data_out[2], 1);
      #1 reset = 1'b1;
      #1;
      chk("async_reset_data_out", data_out, 0);
      chk("async_reset_busy", busy, 0);
      @(posedge clk); #2 reset = 1'b0;
      front = 0; busy_end = -1;
`ifdef NEOPIXEL_DOUBLE_BUFFER_EN
      do_write(2, 0, 8'h96);
`endif
      do_flush(1, 8'h04);
      wait_idle();

      // Out-of-range write addresses leave the RAM untouched.
      do_write(0, 0, 8'h5A);
      do_write(0, 75, 8'hC3);
      do_write(0, 128, 8'hC3);
      do_write(0, 255, 8'hC3);
      do_flush(1, 8'h01);
      wait_idle();

      // Randomised images, lengths and masks.
      for (int r = 0; r < 3; r++) begin
         len  = $urandom_range(3, 1);
         mask = NS'($urandom_range(255, 1));
         for (int i = 0; i < NS; i++)
            if (mask[i])
               for (int a = 0; a < len; a++) do_write(i, a, 8'($urandom));
         do_flush(len, mask);
         wait_idle();
      end

      repeat (5) @(posedge clk);
      #1;
      chk("pending_pulses", pq.size(), 0);
      chk("pending_busy", bq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
